// File: rtl/data_mem_if.sv
// data_mem_if: access bus for data_mem_ctrl.
//   master (datapath side): drives WE, A, WD, clr_req; observes RD, busy, wr_drop, taps.
//   slave  (memory side)  : the reverse.
interface data_mem_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int TAP_N  = 8
);
   logic                    WE;
   logic [ADDR_W-1:0]       A;
   logic [DATA_W-1:0]       WD;
   logic                    clr_req;
   logic [DATA_W-1:0]       RD;
   logic                    busy;
   logic                    wr_drop;
   logic [TAP_N*DATA_W-1:0] taps;

   modport master (output WE, A, WD, clr_req, input RD, busy, wr_drop, taps);
   modport slave  (input WE, A, WD, clr_req, output RD, busy, wr_drop, taps);
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data RAM with a one-word-per-cycle clear sweep,
// software clear request, selectable read latency, optional hard-wired zero
// word 0 and registered taps mirroring the low TAP_N words.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-low (restarts the clear sweep)
//   bus   data_mem_if.slave: WE/A/WD/clr_req in, RD/busy/wr_drop/taps out
module data_mem_ctrl #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int TAP_N      = 8,
   parameter int RD_LAT     = 0,
   parameter int ZERO_ADDR0 = 1
) (
   input  logic       clk,
   input  logic       rst,
   data_mem_if.slave  bus
);

   localparam int DEPTH = 2**ADDR_W;
   // ptr carries one extra bit so the last-word compare never aliases to 0
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                        state_q, state_d;
   logic [ADDR_W:0]               ptr_q, ptr_d;
   logic                          wr_drop_q, wr_drop_d;
   logic [TAP_N-1:0][DATA_W-1:0]  tap_q, tap_d;

   logic                          mem_we;
   logic [ADDR_W-1:0]             mem_waddr;
   logic [DATA_W-1:0]             mem_wdata;
   logic [DATA_W-1:0]             rd_raw;
   logic                          zero_hit;

   logic [DATA_W-1:0] mem [DEPTH];

   assign zero_hit = (ZERO_ADDR0 != 0) && (bus.A == '0);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wr_drop_d = wr_drop_q;
      tap_d     = tap_q;
      mem_we    = 1'b0;
      mem_waddr = bus.A;
      mem_wdata = bus.WD;
      case (state_q)
         S_CLEAR: begin
            // sweep owns the write port; host writes are rejected and flagged
            mem_we    = 1'b1;
            mem_waddr = ptr_q[ADDR_W-1:0];
            mem_wdata = '0;
            ptr_d     = ptr_q + 1'b1;
            if (ptr_q == LAST) begin
               state_d = S_IDLE;
               ptr_d   = '0;
            end
            if (bus.WE) wr_drop_d = 1'b1;
         end
         default: begin
            // a write in the clr_req cycle still lands before the sweep starts
            if (bus.WE && !zero_hit) mem_we = 1'b1;
            if (bus.clr_req) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
            end
         end
      endcase
      // taps shadow every array write (host or sweep) to their index
      for (int i = 0; i < TAP_N; i++)
         if (mem_we && mem_waddr == ADDR_W'(i)) tap_d[i] = mem_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_CLEAR;
         ptr_q     <= '0;
         wr_drop_q <= 1'b0;
         tap_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         wr_drop_q <= wr_drop_d;
         tap_q     <= tap_d;
      end
   end

   // array is deliberately not reset; the sweep zeroes it
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign rd_raw = (state_q == S_CLEAR || zero_hit) ? '0 : mem[bus.A];

   generate
      if (RD_LAT != 0) begin : g_rd_reg
         logic [DATA_W-1:0] rd_q, rd_d;
         // sampled before the array update, so read-during-write gives old data
         assign rd_d = rd_raw;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) rd_q <= '0;
            else      rd_q <= rd_d;
         end
         assign bus.RD = rd_q;
      end else begin : g_rd_comb
         assign bus.RD = rd_raw;
      end
   endgenerate

   assign bus.busy    = (state_q == S_CLEAR);
   assign bus.wr_drop = wr_drop_q;
   assign bus.taps    = tap_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: two DUTs (combinational and registered read) share stimulus.
module tb_data_mem_ctrl;

   logic clk, rst;
   int   checks = 0;
   int   errors = 0;

   data_mem_if #(.DATA_W(8), .ADDR_W(8), .TAP_N(8)) b0 ();
   data_mem_if #(.DATA_W(8), .ADDR_W(8), .TAP_N(8)) b1 ();

   assign b1.WE      = b0.WE;
   assign b1.A       = b0.A;
   assign b1.WD      = b0.WD;
   assign b1.clr_req = b0.clr_req;

   data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .TAP_N(8), .RD_LAT(0), .ZERO_ADDR0(1))
      dut0 (.clk(clk), .rst(rst), .bus(b0));
   data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .TAP_N(8), .RD_LAT(1), .ZERO_ADDR0(1))
      dut1 (.clk(clk), .rst(rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one posedge, then return at the following negedge (inputs change here)
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // count cycles until busy drops, bounded
   task automatic count_busy(output int n);
      n = 0;
      while (b0.busy && n < 1000) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b0; b0.WE = 1'b1; b0.A = 8'd5; b0.WD = 8'hAA; b0.clr_req = 1'b0;
      step(); #1;
      checks++; if (b0.busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %0b exp 1", b0.busy); end
      checks++; if (b0.wr_drop !== 1'b0) begin errors++; $display("FAIL rst_wr_drop got %0b exp 0", b0.wr_drop); end
      checks++; if (b0.taps !== 64'h0) begin errors++; $display("FAIL rst_taps got %h exp 0", b0.taps); end
      checks++; if (b1.RD !== 8'h00) begin errors++; $display("FAIL rst_rd1 got %h exp 00", b1.RD); end
      @(negedge clk); rst = 1'b1;
      step(); #1;
      checks++; if (b0.RD !== 8'h00) begin errors++; $display("FAIL sweep_rd0 got %h exp 00", b0.RD); end
      checks++; if (b0.wr_drop !== 1'b1) begin errors++; $display("FAIL sweep_wr_drop got %0b exp 1", b0.wr_drop); end
      count_busy(n);
      n = n + 1;
      checks++; if (n !== 256) begin errors++; $display("FAIL sweep_len got %0d exp 256", n); end
      b0.WE = 1'b0; #1;
      checks++; if (b0.RD !== 8'h00) begin errors++; $display("FAIL mem5_clear got %h exp 00", b0.RD); end
      step();
      checks++; if (b1.RD !== 8'h00) begin errors++; $display("FAIL mem5_clear_rd1 got %h exp 00", b1.RD); end
   endtask

   task automatic test_write_read();
      b0.WE = 1'b1; b0.A = 8'd3; b0.WD = 8'h5C;
      step();
      b0.WE = 1'b0; #1;
      checks++; if (b0.RD !== 8'h5C) begin errors++; $display("FAIL wr_rd0 got %h exp 5c", b0.RD); end
      checks++; if (b0.taps !== 64'h00000000_5C000000) begin errors++; $display("FAIL wr_taps got %h exp 5c000000", b0.taps); end
      checks++; if (b1.RD !== 8'h00) begin errors++; $display("FAIL wr_rd1_old got %h exp 00", b1.RD); end
      step();
      checks++; if (b1.RD !== 8'h5C) begin errors++; $display("FAIL wr_rd1 got %h exp 5c", b1.RD); end
   endtask

   task automatic test_zero_addr();
      b0.WE = 1'b1; b0.A = 8'd0; b0.WD = 8'hFF;
      step();
      b0.WE = 1'b0; #1;
      checks++; if (b0.RD !== 8'h00) begin errors++; $display("FAIL zero_rd0 got %h exp 00", b0.RD); end
      checks++; if (b0.taps[7:0] !== 8'h00) begin errors++; $display("FAIL zero_tap0 got %h exp 00", b0.taps[7:0]); end
      checks++; if (b0.wr_drop !== 1'b1) begin errors++; $display("FAIL zero_wr_drop got %0b exp 1", b0.wr_drop); end
      checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %0b exp 0", b0.busy); end
      step();
      checks++; if (b1.RD !== 8'h00) begin errors++; $display("FAIL zero_rd1 got %h exp 00", b1.RD); end
   endtask

   task automatic test_clear();
      int n;
      for (int i = 1; i < 7; i++) begin
         b0.WE = 1'b1; b0.A = 8'(i); b0.WD = 8'(i * 8'h11);
         step();
      end
      // last write shares the cycle with clr_req and must still land
      b0.WE = 1'b1; b0.A = 8'd7; b0.WD = 8'h77; b0.clr_req = 1'b1;
      step();
      b0.WE = 1'b0; b0.clr_req = 1'b0; b0.A = 8'd2; #1;
      checks++; if (b0.busy !== 1'b1) begin errors++; $display("FAIL clr_busy got %0b exp 1", b0.busy); end
      checks++; if (b0.taps !== 64'h77665544_33221100) begin errors++; $display("FAIL clr_taps_full got %h exp 7766554433221100", b0.taps); end
      checks++; if (b0.RD !== 8'h00) begin errors++; $display("FAIL clr_rd_busy got %h exp 00", b0.RD); end
      for (int i = 0; i < 20; i++) step();
      b0.clr_req = 1'b1; step(); b0.clr_req = 1'b0;
      count_busy(n);
      n = n + 21;
      checks++; if (n !== 256) begin errors++; $display("FAIL clr_len got %0d exp 256", n); end
      checks++; if (b0.taps !== 64'h0) begin errors++; $display("FAIL clr_taps got %h exp 0", b0.taps); end
      for (int i = 1; i < 8; i++) begin
         b0.A = 8'(i); #1;
         checks++; if (b0.RD !== 8'h00) begin errors++; $display("FAIL clr_rd A=%0d got %h exp 00", i, b0.RD); end
      end
      step();
      checks++; if (b1.RD !== 8'h00) begin errors++; $display("FAIL clr_rd1 got %h exp 00", b1.RD); end
   endtask

   task automatic test_reset_mid();
      int n;
      b0.clr_req = 1'b1; step(); b0.clr_req = 1'b0;
      for (int i = 0; i < 100; i++) step();
      rst = 1'b0; #1;
      checks++; if (b0.busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %0b exp 1", b0.busy); end
      checks++; if (b0.wr_drop !== 1'b0) begin errors++; $display("FAIL mid_wr_drop got %0b exp 0", b0.wr_drop); end
      step(); rst = 1'b1;
      count_busy(n);
      checks++; if (n !== 256) begin errors++; $display("FAIL mid_len got %0d exp 256", n); end
   endtask

   task automatic test_back_to_back();
      b0.WE = 1'b1; b0.A = 8'd9; b0.WD = 8'h12;
      step();
      b0.WD = 8'h34;
      step();
      checks++; if (b1.RD !== 8'h12) begin errors++; $display("FAIL rdw_old got %h exp 12", b1.RD); end
      b0.WE = 1'b0; #1;
      checks++; if (b0.RD !== 8'h34) begin errors++; $display("FAIL rdw_rd0 got %h exp 34", b0.RD); end
      step();
      checks++; if (b1.RD !== 8'h34) begin errors++; $display("FAIL rdw_new got %h exp 34", b1.RD); end
      checks++; if (b0.wr_drop !== 1'b0) begin errors++; $display("FAIL rdw_wr_drop got %0b exp 0", b0.wr_drop); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero_addr();
      test_clear();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
